// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the data-memory bus: CTRL/PRESET/COUNT window, IRQ to HWInt.
// Define BUS_TIMER_BYTE_WRITE_EN to honour partial byte enables on CTRL/PRESET writes.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
  parameter logic [1:0]  DEFAULT_MODE = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state;
  logic        en, im, irq_flag;
  logic [1:0]  mode;
  logic [31:0] preset, count;

  logic        hit, wr_any, wr_ctrl, wr_preset;
  logic [1:0]  offset;
  logic [3:0]  ctrl_new;
  logic [31:0] preset_new, ctrl_word;
  logic        unused_bits;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = addr[3:2];
  assign unused_bits = ^addr[1:0];
  assign ctrl_word   = {28'h0, im, mode, en};

`ifdef BUS_TIMER_BYTE_WRITE_EN
  assign wr_any = hit && (byteen != 4'b0000);

  always_comb begin
    preset_new = preset;
    for (int b = 0; b < 4; b++)
      if (byteen[b]) preset_new[8*b +: 8] = wdata[8*b +: 8];
    ctrl_new = byteen[0] ? wdata[3:0] : ctrl_word[3:0];
  end
`else
  assign wr_any = hit && (byteen == 4'b1111);

  always_comb begin
    preset_new = wdata;
    ctrl_new   = wdata[3:0];
  end
`endif

  assign wr_ctrl   = wr_any && (offset == 2'd0);
  assign wr_preset = wr_any && (offset == 2'd1);

  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (offset)
        2'd0:    rdata = ctrl_word;
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'h0;
      endcase
    end
  end

  // Flag and mask are both flops, so irq has no path from the bus inputs.
  assign irq = irq_flag & im;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      en       <= 1'b0;
      mode     <= DEFAULT_MODE;
      im       <= 1'b0;
      preset   <= 32'h0;
      count    <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;

      case (state)
        S_IDLE: if (en) state <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) state <= S_IDLE;
          else if (count == 32'h0) begin
            state    <= S_INT;
            irq_flag <= 1'b1;
          end else count <= count - 32'h1;
        end
        S_INT: begin
          state <= S_IDLE;
          if (mode == 2'b01) irq_flag <= 1'b0;
          else               en       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Bus writes come last so a CTRL write overrides the INT-state En clear.
      if (wr_ctrl) begin
        en   <= ctrl_new[0];
        mode <= ctrl_new[2:1];
        im   <= ctrl_new[3];
      end
      if (wr_preset) preset <= preset_new;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: expectations queued at stimulus time, popped per sampled cycle.
module tb_bus_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  byteen;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  bus_timer dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .byteen(byteen), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be;
    @(posedge clk);
    @(negedge clk);
    byteen = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; byteen = 4'b0000;
    #1;
    d = rdata;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    do_reset();
    bus_write(A_PRE, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    step(3);
    bus_read(A_CNT, d);
    n_tests++; if (d !== 32'd2) begin n_fail++; $display("FAIL pre_reset_count got %h want %h", d, 32'd2); end
    reset = 1'b0;
    #1;
    bus_read(A_CTRL, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", d); end
    bus_read(A_PRE, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_preset got %h want 0", d); end
    bus_read(A_CNT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", d); end
    @(negedge clk);
    reset = 1'b1;
    // Drive irq high, then check that reset drops it without waiting for a clock edge.
    bus_write(A_CTRL, 32'h9, 4'hF);
    step(3);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_before_reset got %b want 1", irq); end
    reset = 1'b0;
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_async_reset got %b want 0", irq); end
    @(negedge clk);
    reset = 1'b1;
    step(4);
    bus_read(A_CTRL, d);
    n_tests++; if (d !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset ctrl %h irq %b want 0 0", d, irq); end
  endtask

  task automatic test_one_shot;
    logic [31:0] d, e;
    do_reset();
    bus_write(A_PRE, 32'd5, 4'hF);
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back((k >= 2) ? ((k - 2 >= 5) ? 32'd0 : 32'd5 - 32'(k - 2)) : 32'd0);
      exp_q.push_back({31'h0, (k >= 8) ? 1'b1 : 1'b0});
    end
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      bus_read(A_CNT, d);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL oneshot_count edge %0d got %h want %h", k, d, e); end
      e = exp_q.pop_front();
      n_tests++; if (irq !== e[0]) begin n_fail++; $display("FAIL oneshot_irq edge %0d got %b want %b", k, irq, e[0]); end
    end
    bus_read(A_CTRL, d);
    n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl_after got %h want 8", d); end
    bus_write(A_CTRL, 32'h8, 4'hF);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_auto_reload;
    logic [31:0] e;
    do_reset();
    bus_write(A_PRE, 32'd2, 4'hF);
    for (int k = 1; k <= 24; k++)
      exp_q.push_back({31'h0, (k >= 5 && (k - 5) % 6 == 0) ? 1'b1 : 1'b0});
    bus_write(A_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 24; k++) begin
      step(1);
      e = exp_q.pop_front();
      n_tests++; if (irq !== e[0]) begin n_fail++; $display("FAIL reload_irq edge %0d got %b want %b", k, irq, e[0]); end
    end
    bus_write(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_mask_addr;
    logic [31:0] d;
    do_reset();
    bus_write(A_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq edge %0d got %b want 0", k, irq); end
    end
    bus_read(A_CTRL, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL masked_ctrl got %h want 0", d); end
    bus_write(A_CTRL, 32'h8, 4'hF);
    step(1);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL unmask_clears_flag got %b want 0", irq); end
    bus_write(A_PRE, 32'h1234, 4'hF);
    bus_write(BASE + 32'h14, 32'hBEEF, 4'hF);
    bus_write(A_CNT, 32'hDEAD, 4'hF);
    bus_write(BASE + 32'hC, 32'hCAFE, 4'hF);
    bus_read(BASE + 32'h10, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL read_miss got %h want 0", d); end
    bus_read(BASE + 32'h14, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL read_miss_alias got %h want 0", d); end
    bus_read(BASE + 32'h7, d);
    n_tests++; if (d !== 32'h1234) begin n_fail++; $display("FAIL preset_low_bits got %h want 1234", d); end
    bus_read(A_CNT, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL count_write_ignored got %h want 0", d); end
    bus_read(BASE + 32'hC, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL offset3_read got %h want 0", d); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d, e;
    // PRESET written mid-count only takes effect at the next reload.
    do_reset();
    bus_write(A_PRE, 32'd5, 4'hF);
    bus_write(A_CTRL, 32'h3, 4'hF);
    step(4);
    bus_read(A_CNT, d);
    n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL sim_count_pre got %h want 3", d); end
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd7);
    bus_write(A_PRE, 32'd7, 4'hF);
    for (int k = 5; k <= 11; k++) begin
      if (k > 5) step(1);
      bus_read(A_CNT, d);
      e = exp_q.pop_front();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL sim_count edge %0d got %h want %h", k, d, e); end
    end
    // CTRL write in the INT cycle keeps En set and restarts the one-shot.
    do_reset();
    bus_write(A_CTRL, 32'h9, 4'hF);
    step(3);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL win_irq_first got %b want 1", irq); end
    bus_write(A_CTRL, 32'h9, 4'hF);
    bus_read(A_CTRL, d);
    n_tests++; if (d !== 32'h9) begin n_fail++; $display("FAIL win_ctrl got %h want 9", d); end
    step(1);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL win_flag_cleared got %b want 0", irq); end
    step(2);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL win_irq_again got %b want 1", irq); end
    // Clearing En while in LOAD still loads COUNT, then the timer parks.
    do_reset();
    bus_write(A_PRE, 32'd4, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    step(1);
    bus_write(A_CTRL, 32'h0, 4'hF);
    step(2);
    bus_read(A_CNT, d);
    n_tests++; if (d !== 32'd4) begin n_fail++; $display("FAIL load_then_stop got %h want 4", d); end
  endtask

  task automatic test_byte_en;
    logic [31:0] d, e;
    do_reset();
    bus_write(A_PRE, 32'h1234_5678, 4'hF);
`ifdef BUS_TIMER_BYTE_WRITE_EN
    exp_q.push_back(32'h1234_56FF);
    exp_q.push_back(32'hAABB_CCFF);
`else
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
`endif
    exp_q.push_back(32'h0);
    bus_write(A_PRE, 32'h0000_00FF, 4'b0001);
    bus_read(A_PRE, d);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL byteen_low got %h want %h", d, e); end
    bus_write(A_PRE, 32'hAABB_CCDD, 4'b1110);
    bus_write(A_PRE, 32'h5555_5555, 4'b0000);
    bus_read(A_PRE, d);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL byteen_upper got %h want %h", d, e); end
    bus_write(A_CTRL, 32'hFFFF_FF00, 4'b1110);
    bus_read(A_CTRL, d);
    e = exp_q.pop_front();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL byteen_ctrl got %h want %h", d, e); end
  endtask

  initial begin
    reset = 1'b0; addr = 32'h0; wdata = 32'h0; byteen = 4'h0;
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mask_addr();
    test_simultaneous();
    test_byte_en();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
